// File: rtl/faux_hd_fis_scheduler.sv
// Transmit scheduler between the faux HD command layer and the transport layer.
// Latches FIS send requests, issues them by fixed priority and tracks each through the ready/busy handshake with retry.
module faux_hd_fis_scheduler #(
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_TIMEOUT = 16,
    parameter int RETRY_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_reg_stb,
    input  logic        req_dev_bits_stb,
    input  logic        req_pio_stb,
    input  logic        req_dma_act_stb,
    input  logic        req_data_stb,
    input  logic        transport_layer_ready,
    input  logic        xmit_error,
    input  logic        remote_abort,
    output logic        send_reg_stb,
    output logic        send_dev_bits_stb,
    output logic        send_pio_stb,
    output logic        send_dma_act_stb,
    output logic        send_data_stb,
    output logic [4:0]  pending,
    output logic        busy,
    output logic        fis_done_stb,
    output logic        fis_fail_stb,
    output logic [2:0]  fis_type,
    output logic        req_overrun,
    output logic [15:0] retry_total
);
    localparam int AW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TMAX = (BUSY_TIMEOUT > RETRY_GAP) ? BUSY_TIMEOUT : RETRY_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [AW-1:0] ATTEMPT_MAX  = AW'(MAX_RETRY);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(RETRY_GAP);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_BACKOFF   = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [4:0]      r_pending;
    logic [2:0]      r_fis_type, w_type_next;
    logic [AW-1:0]   r_attempt, w_attempt_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic            r_err, w_err_next;
    logic [4:0]      r_send;
    logic            r_done, r_fail;
    logic            r_overrun;
    logic [15:0]     r_retry_total;

    logic [4:0]      w_req;
    logic [2:0]      w_winner;
    logic            w_err_any;
    logic            w_issue, w_done_next, w_fail_next, w_clear, w_retry_inc, w_retry_path;
    logic [4:0]      w_send_next, w_clear_mask, w_pending_next;

    assign w_req     = {req_data_stb, req_dma_act_stb, req_pio_stb, req_dev_bits_stb, req_reg_stb};
    assign w_err_any = r_err | xmit_error | remote_abort;

    // Lowest set index wins.
    always_comb begin
        w_winner = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (r_pending[i]) w_winner = 3'(i);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_type_next    = r_fis_type;
        w_attempt_next = r_attempt;
        w_timer_next   = r_timer;
        w_err_next     = r_err;
        w_issue        = 1'b0;
        w_done_next    = 1'b0;
        w_fail_next    = 1'b0;
        w_clear        = 1'b0;
        w_retry_inc    = 1'b0;
        w_retry_path   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|r_pending) && transport_layer_ready) begin
                    w_type_next    = w_winner;
                    w_attempt_next = '0;
                    w_issue        = 1'b1;
                end
            end
            S_WAIT_BUSY: begin
                w_err_next = w_err_any;
                if (!transport_layer_ready) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_retry_path = 1'b1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                w_err_next = w_err_any;
                if (transport_layer_ready) begin
                    if (w_err_any) begin
                        w_retry_path = 1'b1;
                    end else begin
                        w_done_next  = 1'b1;
                        w_clear      = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                // Timer parks at the gap value until the transport layer is ready again.
                if (r_timer != GAP_LAST) begin
                    w_timer_next = r_timer + 1'b1;
                end else if (transport_layer_ready) begin
                    w_issue = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_retry_path) begin
            if (r_attempt < ATTEMPT_MAX) begin
                w_attempt_next = r_attempt + 1'b1;
                w_retry_inc    = 1'b1;
                w_timer_next   = '0;
                w_state_next   = S_BACKOFF;
            end else begin
                w_fail_next  = 1'b1;
                w_clear      = 1'b1;
                w_state_next = S_IDLE;
            end
        end

        if (w_issue) begin
            w_timer_next = '0;
            w_err_next   = 1'b0;
            w_state_next = S_WAIT_BUSY;
        end
    end

    assign w_send_next    = w_issue ? (5'd1 << w_type_next) : 5'd0;
    assign w_clear_mask   = w_clear ? (5'd1 << r_fis_type) : 5'd0;
    // A fresh request in the completion cycle keeps its bit set.
    assign w_pending_next = (r_pending & ~w_clear_mask) | w_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_fis_type    <= '0;
            r_attempt     <= '0;
            r_timer       <= '0;
            r_err         <= 1'b0;
            r_send        <= '0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_overrun     <= 1'b0;
            r_retry_total <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_fis_type <= w_type_next;
            r_attempt  <= w_attempt_next;
            r_timer    <= w_timer_next;
            r_err      <= w_err_next;
            r_send     <= w_send_next;
            r_done     <= w_done_next;
            r_fail     <= w_fail_next;
            if (|(w_req & r_pending)) r_overrun <= 1'b1;
            if (w_retry_inc && (r_retry_total != 16'hFFFF)) r_retry_total <= r_retry_total + 16'd1;
        end
    end

    assign send_reg_stb      = r_send[0];
    assign send_dev_bits_stb = r_send[1];
    assign send_pio_stb      = r_send[2];
    assign send_dma_act_stb  = r_send[3];
    assign send_data_stb     = r_send[4];
    assign pending           = r_pending;
    assign busy              = (r_state != S_IDLE);
    assign fis_done_stb      = r_done;
    assign fis_fail_stb      = r_fail;
    assign fis_type          = r_fis_type;
    assign req_overrun       = r_overrun;
    assign retry_total       = r_retry_total;
endmodule

// File: tb/tb_faux_hd_fis_scheduler.sv
// Bench for faux_hd_fis_scheduler: directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_faux_hd_fis_scheduler;
    localparam int MAX_RETRY    = 3;
    localparam int BUSY_TIMEOUT = 16;
    localparam int RETRY_GAP    = 4;

    localparam int PH_IDLE     = 0;
    localparam int PH_ACCEPT   = 1;
    localparam int PH_INFLIGHT = 2;
    localparam int PH_GAP      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req = '0;
    logic        rdy = 1'b0;
    logic        xerr = 1'b0;
    logic        rab = 1'b0;

    logic        send_reg_stb, send_dev_bits_stb, send_pio_stb, send_dma_act_stb, send_data_stb;
    logic [4:0]  pending;
    logic        busy, fis_done_stb, fis_fail_stb, req_overrun;
    logic [2:0]  fis_type;
    logic [15:0] retry_total;

    faux_hd_fis_scheduler #(
        .MAX_RETRY(MAX_RETRY), .BUSY_TIMEOUT(BUSY_TIMEOUT), .RETRY_GAP(RETRY_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_reg_stb(req[0]), .req_dev_bits_stb(req[1]), .req_pio_stb(req[2]),
        .req_dma_act_stb(req[3]), .req_data_stb(req[4]),
        .transport_layer_ready(rdy), .xmit_error(xerr), .remote_abort(rab),
        .send_reg_stb(send_reg_stb), .send_dev_bits_stb(send_dev_bits_stb),
        .send_pio_stb(send_pio_stb), .send_dma_act_stb(send_dma_act_stb),
        .send_data_stb(send_data_stb),
        .pending(pending), .busy(busy), .fis_done_stb(fis_done_stb), .fis_fail_stb(fis_fail_stb),
        .fis_type(fis_type), .req_overrun(req_overrun), .retry_total(retry_total)
    );

    always #5 clk = ~clk;

    logic [32:0] dut_vec;
    logic        send_any;
    assign dut_vec  = {send_data_stb, send_dma_act_stb, send_pio_stb, send_dev_bits_stb, send_reg_stb,
                       pending, busy, fis_done_stb, fis_fail_stb, fis_type, req_overrun, retry_total};
    assign send_any = |dut_vec[32:28];

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;

    // Reference model: expected registered outputs for the next cycle.
    bit [4:0] m_pend;
    bit       m_ovr;
    int       m_retry;
    int       m_phase;
    int       m_type;
    int       m_tries;
    int       m_cyc;
    int       m_strobe_cyc;
    int       m_gap_start;
    bit       m_err;
    bit [4:0] m_clr;
    bit [4:0] e_send;
    bit       e_done, e_fail;
    bit       m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, tb_cyc, act, exp);
        end
    endtask

    function automatic int lowest_set(input bit [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [32:0] exp_vec();
        return {e_send, m_pend, (m_phase != PH_IDLE), e_done, e_fail, 3'(m_type), m_ovr, 16'(m_retry)};
    endfunction

    function automatic void m_issue();
        e_send       = 5'(1 << m_type);
        m_strobe_cyc = m_cyc + 1;
        m_err        = 1'b0;
        m_phase      = PH_ACCEPT;
    endfunction

    function automatic void m_attempt_failed();
        if (m_tries <= MAX_RETRY) begin
            m_tries++;
            if (m_retry < 65535) m_retry++;
            m_gap_start = m_cyc + 1;
            m_phase     = PH_GAP;
        end else begin
            e_fail  = 1'b1;
            m_clr   = 5'(1 << m_type);
            m_phase = PH_IDLE;
        end
    endfunction

    function automatic void model_step();
        m_cyc++;
        e_send = '0;
        e_done = 1'b0;
        e_fail = 1'b0;
        m_clr  = '0;
        if (!rst) begin
            m_pend = '0; m_ovr = 1'b0; m_retry = 0; m_phase = PH_IDLE;
            m_type = 0; m_tries = 0; m_err = 1'b0; m_valid = 1'b1;
            return;
        end
        if ((req & m_pend) != 0) m_ovr = 1'b1;
        case (m_phase)
            PH_IDLE: if (m_pend != 0 && rdy) begin
                m_type  = lowest_set(m_pend);
                m_tries = 1;
                m_issue();
            end
            PH_ACCEPT: begin
                m_err |= (xerr | rab);
                if (!rdy) m_phase = PH_INFLIGHT;
                else if (m_cyc - m_strobe_cyc == BUSY_TIMEOUT - 1) m_attempt_failed();
            end
            PH_INFLIGHT: begin
                m_err |= (xerr | rab);
                if (rdy) begin
                    if (m_err) m_attempt_failed();
                    else begin
                        e_done  = 1'b1;
                        m_clr   = 5'(1 << m_type);
                        m_phase = PH_IDLE;
                    end
                end
            end
            default: if (m_cyc - m_gap_start >= RETRY_GAP && rdy) m_issue();
        endcase
        m_pend = (m_pend & ~m_clr) | req;
    endfunction

    // One clock: compare on the falling edge, advance the model, then move past the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (m_valid) chk("cycle_outputs", dut_vec, exp_vec());
        model_step();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; xerr = 1'b0; rab = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!send_any && n < 64) begin
            cycle();
            n++;
        end
        if (!send_any) chk("strobe_seen", send_any, 1);
    endtask

    // Accept the strobed FIS, optionally inject an error mid-flight, return ready and report the outcome.
    task automatic do_xfer(input int kind, output int typ, output bit done, output bit fail, output int scyc);
        wait_strobe();
        typ  = fis_type;
        scyc = tb_cyc;
        rdy  = 1'b0;
        cycle();
        xerr = (kind == 1);
        rab  = (kind == 2);
        cycle();
        xerr = 1'b0;
        rab  = 1'b0;
        cycle();
        rdy = 1'b1;
        cycle();
        done = fis_done_stb;
        fail = fis_fail_stb;
        $display("xfer type=%0d err_kind=%0d done=%0d fail=%0d retry_total=%0d", typ, kind, done, fail, retry_total);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", tb_cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int  typ, s0, s1, n, sends;
        bit  dn, fl;
        int  exp_types[3];
        exp_types[0] = 0; exp_types[1] = 2; exp_types[2] = 4;

        // Reset state
        do_reset();
        chk("reset_outputs", dut_vec, 33'd0);

        // Single data request
        rdy = 1'b1; req[4] = 1'b1;
        cycle();
        req = '0;
        chk("single_pending", pending, 5'h10);
        chk("single_no_early_strobe", send_any, 0);
        cycle();
        chk("single_strobe", send_data_stb, 1);
        chk("single_type", fis_type, 4);
        rdy = 1'b0;
        repeat (5) cycle();
        rdy = 1'b1;
        cycle();
        chk("single_done", fis_done_stb, 1);
        chk("single_pending_clear", pending, 0);
        $display("single request complete");

        // Priority: data, pio and reg together
        do_reset();
        rdy = 1'b1; req = 5'b10101;
        cycle();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            do_xfer(0, typ, dn, fl, s0);
            chk("prio_type", typ, exp_types[k]);
            chk("prio_done", dn, 1);
        end

        // Error retry: two xmit errors then a clean attempt
        do_reset();
        rdy = 1'b1; req[0] = 1'b1;
        cycle();
        req = '0;
        do_xfer(1, typ, dn, fl, s0);
        chk("retry1_no_done", {dn, fl}, 2'b00);
        do_xfer(1, typ, dn, fl, s1);
        chk("retry_spacing", s1 - s0, 9);
        chk("retry2_no_done", {dn, fl}, 2'b00);
        do_xfer(0, typ, dn, fl, s0);
        chk("retry3_done", {dn, fl}, 2'b10);
        chk("retry_total_2", retry_total, 2);

        // Exhaustion: remote abort on every attempt
        do_reset();
        rdy = 1'b1; req[0] = 1'b1;
        cycle();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            do_xfer(2, typ, dn, fl, s0);
            chk("exhaust_outcome", {dn, fl}, (k == 3) ? 2'b01 : 2'b00);
        end
        chk("exhaust_pending0", pending[0], 0);
        chk("exhaust_retry_total", retry_total, 3);

        // Timeout and overrun
        do_reset();
        rdy = 1'b1; req[3] = 1'b1;
        cycle();
        cycle();
        req = '0;
        chk("overrun_set", req_overrun, 1);
        chk("timeout_first_strobe", send_dma_act_stb, 1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!send_any && n < 64);
        chk("timeout_respacing", n, BUSY_TIMEOUT + RETRY_GAP + 1);
        chk("timeout_retry_total", retry_total, 1);
        do_xfer(0, typ, dn, fl, s0);
        chk("timeout_done", {dn, fl}, 2'b10);
        sends = 0;
        repeat (10) begin
            cycle();
            sends += int'(send_any);
        end
        chk("overrun_single_fis", sends, 0);

        // Reset mid-flight
        do_reset();
        rdy = 1'b1; req[0] = 1'b1;
        cycle();
        req = '0;
        wait_strobe();
        rdy = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("midreset_outputs", dut_vec, 33'd0);
        rst = 1'b1; rdy = 1'b1;
        sends = 0;
        repeat (10) begin
            cycle();
            sends += int'(send_any);
        end
        chk("midreset_no_strobe", sends, 0);
        $display("directed scenarios complete");

        // Randomized traffic
        for (int seg = 0; seg < 12; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 10 : int'($urandom_range(5, 9));
            for (int c = 0; c < 200; c++) begin
                for (int b = 0; b < 5; b++) req[b] = ($urandom_range(0, 9) == 0);
                rdy  = ($urandom_range(0, 9) < pct);
                xerr = ($urandom_range(0, 11) == 0);
                rab  = ($urandom_range(0, 19) == 0);
                rst  = ($urandom_range(0, 299) != 0);
                cycle();
            end
            $display("random segment=%0d ready_pct=%0d retry_total=%0d", seg, pct * 10, retry_total);
        end
        rst = 1'b1; req = '0; xerr = 1'b0; rab = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/faux_hd_fis_scheduler.md
# faux_hd_fis_scheduler

Transmit scheduler between the faux hard-drive command layer and the transport layer in the SATA simulation model. Command-layer FIS send requests (register, DMA-activate, data, PIO-setup, set-device-bits) are latched as pending, arbitrated by fixed priority, and issued one at a time as single-cycle strobes. Each issued FIS is tracked through the transport layer's ready/busy handshake, retried on transmit error or remote abort, and reported as done or failed.

## Interface
Parameters:
- MAX_RETRY, 3: re-issues allowed per FIS after the first attempt.
- BUSY_TIMEOUT, 16: cycles to wait for `transport_layer_ready` to drop after a strobe.
- RETRY_GAP, 4: idle cycles before a re-issue.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_reg_stb, req_dev_bits_stb, req_pio_stb, req_dma_act_stb, req_data_stb  in  1 each  one-cycle send requests from the command layer.
- transport_layer_ready  in  1  high when the transport layer is idle and can accept a FIS.
- xmit_error  in  1  transmit error pulse for the FIS in flight.
- remote_abort  in  1  remote abort pulse for the FIS in flight.
- send_reg_stb, send_dev_bits_stb, send_pio_stb, send_dma_act_stb, send_data_stb  out  1 each  one-cycle issue strobes to the transport layer.
- pending  out  5  pending request bits. Bit 0 reg, 1 dev_bits, 2 pio, 3 dma_act, 4 data.
- busy  out  1  high whenever the state is not IDLE.
- fis_done_stb  out  1  one-cycle pulse when a FIS completes cleanly.
- fis_fail_stb  out  1  one-cycle pulse when a FIS is abandoned after MAX_RETRY re-issues.
- fis_type  out  3  index (0–4) of the FIS in flight. It holds through the done/fail pulse.
- req_overrun  out  1  sticky. Set when a request arrives for a type already pending. Cleared only by reset.
- retry_total  out  16  count of re-issues, saturating at 16'hFFFF.

## Operation
- Reset (`rst` low at an edge) forces the following, regardless of current state:
  - all outputs to 0;
  - state to IDLE;
  - retry and timer counters to 0.
  - No strobe is emitted in the cycle after reset.
- Pending latch: a request strobe sets its pending bit at the next edge. A request for a bit that is already set also sets `req_overrun`; the requests are coalesced and the FIS is sent once.
- A pending bit clears when its FIS completes (done or fail). If a new request for the same type arrives in that same cycle, the set wins and the bit stays 1.
- Arbitration uses fixed priority by lowest index: reg > dev_bits > pio > dma_act > data. Winners are chosen only in IDLE.
- State machine:
  - IDLE: if `pending` is nonzero and `transport_layer_ready`=1:
    - latch the winner into `fis_type`;
    - assert its `send_*_stb` for one cycle;
    - clear the attempt counter and timer;
    - go to WAIT_BUSY.
  - WAIT_BUSY: timer increments each cycle.
    - `transport_layer_ready`=0 → WAIT_DONE.
    - Timer reaching BUSY_TIMEOUT → treated as a failed attempt (retry path).
  - WAIT_DONE: a sticky error flag latches if `xmit_error` or `remote_abort` is seen. When `transport_layer_ready` returns to 1:
    - flag clear → `fis_done_stb`, clear the pending bit, go to IDLE;
    - flag set → retry path.
  - Retry path:
    - attempt < MAX_RETRY → increment attempt and `retry_total`, go to BACKOFF;
    - otherwise → `fis_fail_stb`, clear the pending bit, go to IDLE.
  - BACKOFF: wait RETRY_GAP cycles, then wait for `transport_layer_ready`=1. Re-strobe the same `fis_type` and go to WAIT_BUSY. Arbitration is not re-run, so a higher-priority request does not preempt a retry.
- Invalid state encodings → IDLE, with no strobe.
- `xmit_error`/`remote_abort` are ignored outside WAIT_BUSY/WAIT_DONE. An error in WAIT_BUSY is latched and carried into WAIT_DONE.

## Timing
- Request → issue strobe: 2 cycles minimum.
  - Request high in cycle N; pending visible in N+1; strobe high in N+2, given ready=1 in N+1.
- At most one `send_*_stb` is high in any cycle.
- Back-to-back issue:
  - done pulse in cycle M; next strobe no earlier than M+1;
  - never two strobes without a ready low→high cycle between them, except after a timeout.
- `fis_done_stb` and `fis_fail_stb` are never high together. Each pulse is registered, one cycle after the ready-return edge.
- Timeout: with ready stuck at 1, the retry decision is made BUSY_TIMEOUT cycles after the strobe.
- Re-strobe follows at least RETRY_GAP+1 cycles after the decision.
- `retry_total` saturates with no wrap. The per-FIS attempt counter resets on each new arbitration.

## Test plan
- Single request: pulse `req_data_stb` with ready=1 → `send_data_stb` 2 cycles later. Drop ready for 5 cycles → `fis_done_stb` 1 cycle after ready returns; `pending`=0.
- Priority: pulse req_data, req_pio and req_reg in the same cycle → issue order reg, pio, data, with `fis_type` 0, 2, 4; three done pulses.
- Error retry: `xmit_error` during WAIT_DONE on the first two attempts, clean third → three `send_reg_stb` pulses spaced ≥ RETRY_GAP apart; one done pulse; `retry_total`=2.
- Exhaustion: `remote_abort` on every attempt → 4 strobes total, then `fis_fail_stb`; `pending[0]`=0; `retry_total`=3.
- Timeout and overrun: ready held at 1 after the strobe → re-strobe after 16 + gap cycles. A second `req_dma_act_stb` while bit 3 is pending → `req_overrun`=1 and a single FIS.
- Reset mid-flight: drive `rst` low during WAIT_DONE → next cycle all outputs 0 and `pending`=0; no strobe after `rst` is released until a new request arrives.
